// File: rtl/multiplier_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_arbiter_pkg
//  Description : Shared constants and types for the two-port multiplier
//                arbiter: multiplier latency, port index and op tag.
//  Revision    : 1.0 - initial release
// ============================================================================
package multiplier_arbiter_pkg;

  // Edges from operand capture to registered product
  localparam int MUL_LATENCY = 2;
  localparam int NUM_PORTS   = 2;

  // One-bit port index
  typedef logic port_t;

  // Tag travelling alongside each multiply through the pipeline
  typedef struct packed {
    logic  valid;
    port_t port;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/multiplier_arbiter_mult.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_pipelined
//  Description : 32x32 -> 64 unsigned multiplier. Operands are registered on
//                the first edge, the full product on the second edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_pipelined (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] p_d;
  logic [63:0] p_q;

  // Full-width product of the captured operands
  always_comb begin
    p_d = 64'(a_q) * 64'(b_q);
  end

  // Datapath stages; validity is tracked by the caller's tag pipeline
  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
    p_q <= p_d;
  end

  assign p = p_q;

endmodule
`default_nettype wire

// File: rtl/multiplier_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_arbiter
//  Description : Shares one pipelined multiplier between two request ports
//                with round-robin arbitration, credit-based admission and a
//                per-port in-order response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [63:0] resp0_r,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [63:0] resp1_r
);

  localparam int               PTR_W     = $clog2(RESP_DEPTH);
  localparam int               CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_CNT = (CNT_W + 1)'(RESP_DEPTH);

  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS-1:0] resp_ready;
  logic [NUM_PORTS-1:0] resp_valid;
  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] grant_vec;
  logic [31:0]          req_a       [NUM_PORTS];
  logic [31:0]          req_b       [NUM_PORTS];
  logic [63:0]          resp_r      [NUM_PORTS];
  logic [CNT_W:0]       credit_used [NUM_PORTS];

  logic        run_q, run_d;
  port_t       prio_q, prio_d;
  tag_t        tag_q [MUL_LATENCY];
  tag_t        tag_d [MUL_LATENCY];
  tag_t        tag_wb;
  logic        grant_valid;
  port_t       grant_port;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_p;

  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;

  // A port may issue only while its queued-plus-in-flight results still fit
  assign elig[0] = run_q & req_valid[0] & (credit_used[0] < DEPTH_CNT);
  assign elig[1] = run_q & req_valid[1] & (credit_used[1] < DEPTH_CNT);

  // Round-robin grant, operand mux and tag injection
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = prio_q;
    grant_vec   = '0;
    prio_d      = prio_q;
    run_d       = 1'b1;
    if (elig[0] && elig[1]) begin
      grant_valid = 1'b1;
      grant_port  = prio_q;
    end else if (elig[0]) begin
      grant_valid = 1'b1;
      grant_port  = 1'b0;
    end else if (elig[1]) begin
      grant_valid = 1'b1;
      grant_port  = 1'b1;
    end
    if (grant_valid) begin
      grant_vec[grant_port] = 1'b1;
      prio_d                = ~grant_port;
    end
    mul_a    = grant_port ? req_a[1] : req_a[0];
    mul_b    = grant_port ? req_b[1] : req_b[0];
    tag_d[0] = tag_t'{valid: grant_valid, port: grant_port};
    for (int i = 1; i < MUL_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Arbiter state and tag pipeline; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      prio_q <= 1'b0;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      run_q  <= run_d;
      prio_q <= prio_d;
      for (int i = 0; i < MUL_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign tag_wb = tag_q[MUL_LATENCY-1];

  multiplier_pipelined u_mul (
    .clk (clk),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_resp_fifo
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] infl_q, infl_d;
    logic [63:0]      mem_q [RESP_DEPTH];
    logic             push;
    logic             pop;
    logic             accept;

    assign push           = tag_wb.valid && (tag_wb.port == port_t'(p));
    assign accept         = grant_vec[p];
    assign resp_valid[p]  = (occ_q != '0);
    assign pop            = resp_valid[p] && resp_ready[p];
    assign resp_r[p]      = mem_q[rd_ptr_q];
    assign credit_used[p] = {1'b0, occ_q} + {1'b0, infl_q};

    // Pointer wrap plus occupancy and in-flight bookkeeping
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      infl_d   = infl_q;
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + CNT_W'(1);
        2'b01:   occ_d = occ_q - CNT_W'(1);
        default: occ_d = occ_q;
      endcase
      case ({accept, push})
        2'b10:   infl_d = infl_q + CNT_W'(1);
        2'b01:   infl_d = infl_q - CNT_W'(1);
        default: infl_d = infl_q;
      endcase
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
        infl_q   <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        occ_q    <= occ_d;
        infl_q   <= infl_d;
      end
    end

    // Result storage written two edges after acceptance
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= mul_p;
    end
  end

  assign req0_ready  = grant_vec[0];
  assign req1_ready  = grant_vec[1];
  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_r     = resp_r[0];
  assign resp1_r     = resp_r[1];

endmodule
`default_nettype wire

// File: tb/tb_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_arbiter
//  Description : Self-checking bench for multiplier_arbiter: vector table,
//                directed corner sequences and random traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multiplier_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [63:0] resp0_r, resp1_r;

  always #5 clk = ~clk;

  multiplier_arbiter #(.RESP_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp0_r     (resp0_r),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp1_r     (resp1_r)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each port keeps a queue of accepted-but-not-consumed products; its length
  // is the credit usage, and a result becomes visible two cycles after the
  // acceptance edge (three sample cycles after the sample that saw the grant).
  typedef struct {
    logic [63:0] prod;
    int          acc;
  } pend_t;

  pend_t q0[$];
  pend_t q1[$];
  int    cyc    = 0;
  bit    prio_m = 1'b0;
  bit    run_m  = 1'b0;
  bit    mon_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    run_m = rst_n;
  end

  always @(negedge rst_n) begin
    q0.delete();
    q1.delete();
    prio_m = 1'b0;
    run_m  = 1'b0;
  end

  always @(negedge clk) begin
    bit e0, e1, g0, g1, v0, v1;
    if (mon_en) begin
      if (!rst_n) begin
        check("mon_rst_req0_ready", req0_ready, 0);
        check("mon_rst_req1_ready", req1_ready, 0);
        check("mon_rst_resp0_valid", resp0_valid, 0);
        check("mon_rst_resp1_valid", resp1_valid, 0);
      end else begin
        e0 = run_m && req0_valid && (q0.size() < DEPTH);
        e1 = run_m && req1_valid && (q1.size() < DEPTH);
        g0 = e0 && (!e1 || prio_m == 1'b0);
        g1 = e1 && (!e0 || prio_m == 1'b1);
        v0 = (q0.size() > 0) && (q0[0].acc + 3 <= cyc);
        v1 = (q1.size() > 0) && (q1[0].acc + 3 <= cyc);
        check("mon_req0_ready", req0_ready, g0);
        check("mon_req1_ready", req1_ready, g1);
        check("mon_resp0_valid", resp0_valid, v0);
        check("mon_resp1_valid", resp1_valid, v1);
        if (v0) check("mon_resp0_r", resp0_r, q0[0].prod);
        if (v1) check("mon_resp1_r", resp1_r, q1[0].prod);
        if (v0 && resp0_ready) void'(q0.pop_front());
        if (v1 && resp1_ready) void'(q1.pop_front());
        if (g0) begin
          q0.push_back('{64'(req0_a) * 64'(req0_b), cyc});
          prio_m = 1'b1;
        end
        if (g1) begin
          q1.push_back('{64'(req1_a) * 64'(req1_b), cyc});
          prio_m = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_point();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n      = 1'b0;
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_resp0_valid", resp0_valid, 0);
    check("rst_resp1_valid", resp1_valid, 0);
    drive_point();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 rst_n = 1'b1;
    drive_point();
  endtask

  task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input string nm);
    int acc_c;
    bit got;
    if (p == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (p == 0) ? req0_ready : req1_ready;
    end
    acc_c = cyc + 1;  // index of the acceptance edge
    check({nm, "_accepted"}, got, 1);
    drive_point();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (p == 0) ? resp0_valid : resp1_valid;
    end
    check({nm, "_valid"}, got, 1);
    check({nm, "_latency"}, 64'(cyc - acc_c), 2);
    check({nm, "_r"}, (p == 0) ? resp0_r : resp1_r, exp);
    drive_point();
  endtask

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          n;
    int          idx;
    bit          acc0;
    logic [63:0] got_q[$];
    logic [63:0] exp_seq[3];

    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    int          gport;
    int          idx;
    bit          acc0;
    logic [63:0] got_q[$];
    logic [63:0] exp_seq[3];

    vecs[0] = '{0, 32'd3,          32'd5,          64'd15};
    vecs[1] = '{1, 32'd7,          32'd9,          64'd63};
    vecs[2] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[4] = '{0, 32'd0,          32'hFFFF_FFFF,  64'd0};
    vecs[5] = '{1, 32'h8000_0000,  32'd2,          64'h1_0000_0000};
    vecs[6] = '{0, 32'h1234_5678,  32'h10,         64'h1_2345_6780};
    vecs[7] = '{1, 32'hFFFF_FFFF,  32'd1,          64'hFFFF_FFFF};

    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    do_reset();

    // Vector table: single operations, one at a time
    foreach (vecs[i]) do_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // Both ports streaming: grants alternate starting with port 0
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gport = req0_ready ? 0 : (req1_ready ? 1 : -1);
      check($sformatf("rr_grant%0d", i), 64'(gport), 64'(i % 2));
      drive_point();
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) drive_point();

    // Credit exhaustion on port 1, then one pop releases exactly one credit
    do_reset();
    resp1_ready = 1'b0;
    req1_valid  = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n += int'(req1_ready);
    end
    check("credit_accepts", 64'(n), 4);
    check("credit_blocked", req1_ready, 0);
    drive_point();
    resp1_ready = 1'b1;
    @(negedge clk);
    check("credit_pop_valid", resp1_valid, 1);
    check("credit_pop_cycle_ready", req1_ready, 0);
    drive_point();
    resp1_ready = 1'b0;
    @(negedge clk);
    check("credit_after_pop_ready", req1_ready, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n += int'(req1_ready);
    end
    check("credit_extra_accepts", 64'(n), 1);
    drive_point();
    req1_valid  = 1'b0;
    resp1_ready = 1'b1;
    repeat (10) drive_point();

    // Reset pulse right after an acceptance discards that operation
    do_reset();
    req0_a = 32'd6; req0_b = 32'd7; req0_valid = 1'b1;
    @(negedge clk);
    check("flush_accepted", req0_ready, 1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n += int'(resp0_valid);
    end
    check("flush_no_resp", 64'(n), 0);
    drive_point();
    do_op(0, 32'd9, 32'd9, 64'd81, "after_flush");

    // Port 0 ordered sequence while port 1 streams
    exp_seq[0] = 64'd1; exp_seq[1] = 64'd4; exp_seq[2] = 64'd9;
    idx = 0;
    req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp0_valid) got_q.push_back(resp0_r);
      acc0 = req0_ready;
      drive_point();
      req1_a = $urandom; req1_b = $urandom;
      if (acc0) begin
        idx++;
        if (idx < 3) begin req0_a = 32'(idx + 1); req0_b = 32'(idx + 1); end
        else req0_valid = 1'b0;
      end
    end
    req1_valid = 1'b0;
    check("order_count", 64'(got_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check($sformatf("order_r%0d", i), got_q[i], exp_seq[i]);
    end
    repeat (6) drive_point();

    // Random traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      req0_valid  = ($urandom_range(0, 9) < 7);
      req1_valid  = ($urandom_range(0, 9) < 6);
      resp0_ready = ($urandom_range(0, 9) < 6);
      resp1_ready = ($urandom_range(0, 9) < 5);
      req0_a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      req0_b = ($urandom_range(0, 7) == 0) ? 32'd0         : 32'($urandom);
      req1_a = 32'($urandom);
      req1_b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      drive_point();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    repeat (12) drive_point();
    check("drain_q0_empty", 64'(q0.size()), 0);
    check("drain_q1_empty", 64'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
